// File: rtl/pm_domain_mux_pkg.sv
// Shared arbiter state type, default packet geometry and a clog2 helper for the PM domain mux.
package pm_domain_mux_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int DEF_PKT_W     = 128;
    localparam int DEF_SEL_W     = 3;
    localparam int DEF_BURST_BIT = 127;

    function automatic int clog2(input int value);
        int res;
        res = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >> 1) begin
            res = res + 32'sd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pm_domain_mux_in_fifo.sv
// Per-core inbound FIFO: single clock, wrap-bit pointers; pushes when full and pops when empty are ignored.
module pm_domain_mux_in_fifo
    import pm_domain_mux_pkg::*;
#(
    parameter int PKT_W    = DEF_PKT_W,
    parameter int IN_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [PKT_W-1:0] push_data,
    input  logic             pop,
    output logic [PKT_W-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = clog2(IN_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [PKT_W-1:0] mem_r [IN_DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head_data = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset discards any held packets.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Storage write; contents are don't-care until the pointer makes them visible.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pm_domain_mux.sv
// PM domain packet mux: round-robin outbound arbitration with burst lock, core-select inbound steering.
// Optional per-core traffic counters are built when PM_DOMAIN_MUX_STATS_EN is defined.
module pm_domain_mux
    import pm_domain_mux_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int PKT_W     = DEF_PKT_W,
    parameter int SEL_LSB   = 0,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int BURST_BIT = DEF_BURST_BIT,
    parameter int IN_DEPTH  = 2
) (
    input  logic                       clk_pm_i,
    input  logic                       reset_pm_n_i,
    input  logic [NUM_CORES-1:0]       core_out_valid_i,
    input  logic [NUM_CORES*PKT_W-1:0] core_out_data_i,
    output logic [NUM_CORES-1:0]       core_out_ready_o,
    output logic                       noc_out_valid_o,
    output logic [PKT_W-1:0]           noc_out_data_o,
    input  logic                       noc_out_ready_i,
    input  logic                       noc_in_valid_i,
    input  logic [PKT_W-1:0]           noc_in_data_i,
    output logic                       noc_in_ready_o,
    output logic [NUM_CORES-1:0]       core_in_valid_o,
    output logic [NUM_CORES*PKT_W-1:0] core_in_data_o,
    input  logic [NUM_CORES-1:0]       core_in_ready_i,
    output logic [7:0]                 drop_cnt_o,
    output logic [NUM_CORES*32-1:0]    stats_o
);
    localparam int            CW          = (NUM_CORES > 1) ? clog2(NUM_CORES) : 1;
    localparam logic [CW-1:0] LAST_CORE   = CW'(NUM_CORES - 1);
    localparam logic [CW-1:0] CORE_ONE    = CW'(1);
    localparam logic [31:0]   NUM_CORES_U = 32'(NUM_CORES);

    arb_state_e           state_r;
    logic [CW-1:0]        rr_ptr_r;
    logic [CW-1:0]        lock_core_r;
    logic [CW-1:0]        grant_s;
    logic                 offer_s;
    logic                 ld_s;
    logic                 hs_s;
    logic [PKT_W-1:0]     grant_data_s;
    logic                 noc_out_valid_r;
    logic [PKT_W-1:0]     noc_out_data_r;
    logic [7:0]           drop_cnt_r;
    logic [31:0]          sel_s;
    logic                 in_range_s;
    logic                 in_ready_s;
    logic [NUM_CORES-1:0] push_s;
    logic [NUM_CORES-1:0] full_s;
    logic [NUM_CORES-1:0] empty_s;

    // Grant: pinned while locked, otherwise first valid core at or above rr_ptr with wrap.
    always_comb begin
        grant_s = rr_ptr_r;
        offer_s = 1'b0;
        if (state_r == ARB_LOCK) begin
            grant_s = lock_core_r;
            offer_s = 1'b1;
        end else begin
            for (int k = NUM_CORES - 1; k >= 0; k--) begin
                grant_s = core_out_valid_i[(int'(rr_ptr_r) + k) % NUM_CORES]
                        ? CW'((int'(rr_ptr_r) + k) % NUM_CORES) : grant_s;
                offer_s = offer_s | core_out_valid_i[(int'(rr_ptr_r) + k) % NUM_CORES];
            end
        end
    end

    assign ld_s         = !noc_out_valid_r || noc_out_ready_i;
    assign grant_data_s = core_out_data_i[int'(grant_s)*PKT_W +: PKT_W];
    assign hs_s         = reset_pm_n_i && ld_s && offer_s && core_out_valid_i[grant_s];

    // One-hot accept towards the granted core only.
    always_comb begin
        core_out_ready_o = '0;
        if (reset_pm_n_i && ld_s && offer_s) begin
            core_out_ready_o[grant_s] = 1'b1;
        end else begin
            core_out_ready_o = '0;
        end
    end

    // Output register and arbiter state; both advance only on an accepted packet.
    always_ff @(posedge clk_pm_i) begin
        if (!reset_pm_n_i) begin
            noc_out_valid_r <= 1'b0;
            noc_out_data_r  <= '0;
            state_r         <= ARB_IDLE;
            rr_ptr_r        <= '0;
            lock_core_r     <= '0;
        end else begin
            if (ld_s) begin
                noc_out_valid_r <= hs_s;
                if (hs_s) noc_out_data_r <= grant_data_s;
            end
            if (hs_s) begin
                case (state_r)
                    ARB_IDLE: begin
                        rr_ptr_r <= (grant_s == LAST_CORE) ? '0 : grant_s + CORE_ONE;
                        if (grant_data_s[BURST_BIT]) begin
                            state_r     <= ARB_LOCK;
                            lock_core_r <= grant_s;
                        end
                    end
                    ARB_LOCK: begin
                        if (!grant_data_s[BURST_BIT]) state_r <= ARB_IDLE;
                    end
                    default: state_r <= ARB_IDLE;
                endcase
            end
        end
    end

    assign noc_out_valid_o = noc_out_valid_r;
    assign noc_out_data_o  = noc_out_data_r;

    assign sel_s      = 32'(noc_in_data_i[SEL_LSB +: SEL_W]);
    assign in_range_s = (sel_s < NUM_CORES_U);

    // Inbound steering: ready follows the addressed FIFO; unknown slots always accept (and drop).
    always_comb begin
        push_s     = '0;
        in_ready_s = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            push_s[i]  = noc_in_valid_i && (sel_s == 32'(i));
            in_ready_s = (sel_s == 32'(i)) ? !full_s[i] : in_ready_s;
        end
    end

    assign noc_in_ready_o = in_ready_s;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_in_fifo
        pm_domain_mux_in_fifo #(
            .PKT_W    (PKT_W),
            .IN_DEPTH (IN_DEPTH)
        ) u_fifo (
            .clk       (clk_pm_i),
            .rst_n     (reset_pm_n_i),
            .push      (push_s[gi]),
            .push_data (noc_in_data_i),
            .pop       (core_in_ready_i[gi]),
            .head_data (core_in_data_o[gi*PKT_W +: PKT_W]),
            .full      (full_s[gi]),
            .empty     (empty_s[gi])
        );
        assign core_in_valid_o[gi] = !empty_s[gi];
    end

    // Dropped-packet counter, holding at its maximum.
    always_ff @(posedge clk_pm_i) begin
        if (!reset_pm_n_i) begin
            drop_cnt_r <= 8'd0;
        end else if (noc_in_valid_i && !in_range_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_r;

`ifdef PM_DOMAIN_MUX_STATS_EN
    logic [15:0] out_cnt_r [NUM_CORES];
    logic [15:0] in_cnt_r  [NUM_CORES];

    // Per-core traffic counters, wrapping modulo 2**16.
    always_ff @(posedge clk_pm_i) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!reset_pm_n_i) begin
                out_cnt_r[i] <= 16'd0;
                in_cnt_r[i]  <= 16'd0;
            end else begin
                if (hs_s && (grant_s == CW'(i))) out_cnt_r[i] <= out_cnt_r[i] + 16'd1;
                if (push_s[i] && !full_s[i])     in_cnt_r[i]  <= in_cnt_r[i] + 16'd1;
            end
        end
    end

    // Pack counters as {in_cnt, out_cnt} per core.
    always_comb begin
        stats_o = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            stats_o[i*32 +: 32] = {in_cnt_r[i], out_cnt_r[i]};
        end
    end
`else
    assign stats_o = '0;
`endif

endmodule

// File: tb/tb_pm_domain_mux.sv
// Scoreboard bench for pm_domain_mux (NUM_CORES=2, IN_DEPTH=2); stats checks follow PM_DOMAIN_MUX_STATS_EN.
module tb_pm_domain_mux;
    typedef logic [127:0] pkt_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   core_out_valid_i;
    logic [255:0] core_out_data_i;
    logic [1:0]   core_out_ready_o;
    logic         noc_out_valid_o;
    logic [127:0] noc_out_data_o;
    logic         noc_out_ready_i;
    logic         noc_in_valid_i;
    logic [127:0] noc_in_data_i;
    logic         noc_in_ready_o;
    logic [1:0]   core_in_valid_o;
    logic [255:0] core_in_data_o;
    logic [1:0]   core_in_ready_i;
    logic [7:0]   drop_cnt_o;
    logic [63:0]  stats_o;

    always #5 clk = ~clk;

    pm_domain_mux #(
        .NUM_CORES (2), .PKT_W (128), .SEL_LSB (0), .SEL_W (3), .BURST_BIT (127), .IN_DEPTH (2)
    ) dut (
        .clk_pm_i (clk), .reset_pm_n_i (rst_n),
        .core_out_valid_i (core_out_valid_i), .core_out_data_i (core_out_data_i),
        .core_out_ready_o (core_out_ready_o),
        .noc_out_valid_o (noc_out_valid_o), .noc_out_data_o (noc_out_data_o),
        .noc_out_ready_i (noc_out_ready_i),
        .noc_in_valid_i (noc_in_valid_i), .noc_in_data_i (noc_in_data_i),
        .noc_in_ready_o (noc_in_ready_o),
        .core_in_valid_o (core_in_valid_o), .core_in_data_o (core_in_data_o),
        .core_in_ready_i (core_in_ready_i),
        .drop_cnt_o (drop_cnt_o), .stats_o (stats_o)
    );

    pkt_t src0_q[$], src1_q[$], exp_q[$], in0_q[$], in1_q[$];
    logic [1:0] src_en;
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input pkt_t got, input pkt_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic pkt_t mk(input int core, input int seq, input logic burst);
        pkt_t p;
        p = '0;
        p[127]    = burst;
        p[31:24]  = 8'hA5;
        p[23:16]  = 8'(core);
        p[15:0]   = 16'(seq);
        return p;
    endfunction

    function automatic pkt_t mk_in(input int t, input int seq);
        pkt_t p;
        p = '0;
        p[2:0]   = 3'(t);
        p[47:32] = 16'(seq);
        p[95:88] = 8'h3C;
        return p;
    endfunction

    task automatic apply_src();
        core_out_valid_i[0]     = src_en[0] && (src0_q.size() > 0);
        core_out_valid_i[1]     = src_en[1] && (src1_q.size() > 0);
        core_out_data_i[127:0]   = (src0_q.size() > 0) ? src0_q[0] : '0;
        core_out_data_i[255:128] = (src1_q.size() > 0) ? src1_q[0] : '0;
    endtask

    // One cycle: snapshot handshakes away from the edge, then retire accepted source packets.
    task automatic tick();
        logic [1:0] rdy;
        logic [1:0] vld;
        @(negedge clk);
        rdy = core_out_ready_o;
        vld = core_out_valid_i;
        @(posedge clk);
        #1;
        if (rdy[0] && vld[0]) void'(src0_q.pop_front());
        if (rdy[1] && vld[1]) void'(src1_q.pop_front());
        apply_src();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((src0_q.size() + src1_q.size() + exp_q.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 128'(src0_q.size() + src1_q.size() + exp_q.size()), 128'd0);
    endtask

    task automatic send_in(input pkt_t p, input logic exp_rdy);
        noc_in_valid_i = 1'b1;
        noc_in_data_i  = p;
        #1;
        check("in_ready", 128'(noc_in_ready_o), 128'(exp_rdy));
        if (exp_rdy && p[2:0] == 3'd0) in0_q.push_back(p);
        if (exp_rdy && p[2:0] == 3'd1) in1_q.push_back(p);
        tick();
        noc_in_valid_i = 1'b0;
    endtask

    // Outbound monitor: every NoC handshake must match the next expected packet.
    always @(negedge clk) begin
        pkt_t e;
        if (noc_out_valid_o && noc_out_ready_i) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("out_pkt", noc_out_data_o, e);
        end
    end

    // Inbound monitor: every core-side pop must match that core's expected queue.
    always @(negedge clk) begin
        pkt_t e;
        if (core_in_valid_o[0] && core_in_ready_i[0]) begin
            e = (in0_q.size() > 0) ? in0_q.pop_front() : '1;
            check("in0_pkt", core_in_data_o[127:0], e);
        end
        if (core_in_valid_o[1] && core_in_ready_i[1]) begin
            e = (in1_q.size() > 0) ? in1_q.pop_front() : '1;
            check("in1_pkt", core_in_data_o[255:128], e);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t b7;
        rst_n = 1'b0;
        src_en = 2'b11;
        noc_out_ready_i = 1'b1;
        noc_in_valid_i = 1'b0;
        noc_in_data_i = '0;
        core_in_ready_i = 2'b00;

        // Reset with both cores valid.
        src0_q.push_back(mk(0, 0, 1'b0));
        src1_q.push_back(mk(1, 0, 1'b0));
        apply_src();
        repeat (3) tick();
        check("rst_out_valid", 128'(noc_out_valid_o), 128'd0);
        check("rst_out_data", noc_out_data_o, 128'd0);
        check("rst_core_ready", 128'(core_out_ready_o), 128'd0);
        check("rst_in_valid", 128'(core_in_valid_o), 128'd0);
        check("rst_drop", 128'(drop_cnt_o), 128'd0);
        check("rst_stats", 128'(stats_o), 128'd0);
        rst_n = 1'b1;
        #1;
        check("first_grant", 128'(core_out_ready_o), 128'd1);
        exp_q.push_back(mk(0, 0, 1'b0));
        exp_q.push_back(mk(1, 0, 1'b0));
        drain("drain_rst", 20);

        // Round-robin at one packet per cycle.
        for (int s = 1; s <= 3; s++) begin
            src0_q.push_back(mk(0, s, 1'b0));
            src1_q.push_back(mk(1, s, 1'b0));
            exp_q.push_back(mk(0, s, 1'b0));
            exp_q.push_back(mk(1, s, 1'b0));
        end
        apply_src();
        repeat (7) tick();
        check("rr_rate", 128'(exp_q.size()), 128'd0);
        drain("drain_rr", 20);

        // Burst lock on core1, with core1 idle for two cycles mid-burst.
        for (int s = 4; s <= 6; s++) src0_q.push_back(mk(0, s, 1'b0));
        src1_q.push_back(mk(1, 4, 1'b1));
        src1_q.push_back(mk(1, 5, 1'b1));
        src1_q.push_back(mk(1, 6, 1'b0));
        exp_q.push_back(mk(0, 4, 1'b0));
        exp_q.push_back(mk(1, 4, 1'b1));
        exp_q.push_back(mk(1, 5, 1'b1));
        exp_q.push_back(mk(1, 6, 1'b0));
        exp_q.push_back(mk(0, 5, 1'b0));
        exp_q.push_back(mk(0, 6, 1'b0));
        apply_src();
        tick();
        tick();
        src_en = 2'b01;
        apply_src();
        repeat (2) begin
            tick();
            #1;
            check("lock_stall", 128'(core_out_ready_o), 128'd2);
        end
        src_en = 2'b11;
        apply_src();
        drain("drain_lock", 30);

        // Backpressure holds the output register and blocks all accepts.
        b7 = mk(1, 7, 1'b0);
        src0_q.push_back(mk(0, 7, 1'b0));
        src0_q.push_back(mk(0, 8, 1'b0));
        src1_q.push_back(b7);
        src1_q.push_back(mk(1, 8, 1'b0));
        exp_q.push_back(b7);
        exp_q.push_back(mk(0, 7, 1'b0));
        exp_q.push_back(mk(1, 8, 1'b0));
        exp_q.push_back(mk(0, 8, 1'b0));
        apply_src();
        tick();
        noc_out_ready_i = 1'b0;
        repeat (4) begin
            #1;
            check("bp_ready", 128'(core_out_ready_o), 128'd0);
            check("bp_valid", 128'(noc_out_valid_o), 128'd1);
            check("bp_data", noc_out_data_o, b7);
            tick();
        end
        noc_out_ready_i = 1'b1;
        drain("drain_bp", 30);

        // Inbound: fill core1, check data-dependent ready, then pop.
        send_in(mk_in(1, 1), 1'b1);
        send_in(mk_in(1, 2), 1'b1);
        send_in(mk_in(1, 3), 1'b0);
        send_in(mk_in(0, 4), 1'b1);
        check("in_valid_full", 128'(core_in_valid_o), 128'd3);
        send_in(mk_in(5, 5), 1'b1);
        check("drop_one", 128'(drop_cnt_o), 128'd1);
        core_in_ready_i = 2'b11;
        repeat (2) tick();
        core_in_ready_i = 2'b00;
        check("in_after_pop", 128'(core_in_valid_o), 128'd0);
        check("in_q_left", 128'(in0_q.size() + in1_q.size()), 128'd0);

        // Simultaneous push and pop on core1.
        send_in(mk_in(1, 6), 1'b1);
        core_in_ready_i = 2'b10;
        send_in(mk_in(1, 7), 1'b1);
        #1;
        check("push_pop_valid", 128'(core_in_valid_o), 128'd2);
        tick();
        core_in_ready_i = 2'b00;
        check("push_pop_left", 128'(in1_q.size()), 128'd0);
        check("push_pop_empty", 128'(core_in_valid_o), 128'd0);

        // Drop counter saturation: 300 unroutable packets in total.
        noc_in_valid_i = 1'b1;
        noc_in_data_i = mk_in(6, 8);
        #1;
        check("drop_ready", 128'(noc_in_ready_o), 128'd1);
        repeat (253) tick();
        check("drop_254", 128'(drop_cnt_o), 128'd254);
        repeat (46) tick();
        noc_in_valid_i = 1'b0;
        check("drop_sat", 128'(drop_cnt_o), 128'd255);

`ifdef PM_DOMAIN_MUX_STATS_EN
        check("stats_mix", 128'(stats_o), {64'd0, 16'd4, 16'd9, 16'd1, 16'd9});
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("stats_rst", 128'(stats_o), 128'd0);
        src_en = 2'b11;
        for (int n = 0; n < 70000; n++) begin
            src0_q.push_back(mk(0, n, 1'b0));
            exp_q.push_back(mk(0, n, 1'b0));
        end
        apply_src();
        drain("drain_stats", 70100);
        check("stats_wrap", 128'(stats_o[15:0]), 128'd4464);
`else
        check("stats_off", 128'(stats_o), 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
